// File: rtl/dtw_mem_ctrl_if.sv
// Load and read-out streams between the DTW reference store and its peers.
// The slave modport is the controller side of both streams.
interface dtw_mem_ctrl_if #(
  parameter int width = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [width-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [width-1:0] m_data;
  logic             m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/dtw_mem_ctrl.sv
// Single-port reference BRAM sequencer for the DTW core.
// Loads a stream into BRAM, then replays it through a 2-entry skid buffer.
module dtw_mem_ctrl #(
  parameter int width  = 16,
  parameter int ptrWid = 18,
  parameter int depth  = 2**ptrWid
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ld_start,
  input  logic              rd_start,
  dtw_mem_ctrl_if.slave     st,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic [ptrWid:0]   ref_len,
  output logic              mem_wen,
  output logic [ptrWid-1:0] mem_addr,
  output logic [width-1:0]  mem_din,
  input  logic [width-1:0]  mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READ
  } state_t;

  localparam logic [ptrWid:0] DEPTH = (ptrWid+1)'(depth);
  localparam logic [ptrWid:0] ONE   = 1;

  state_t          state_q, state_d;
  logic [ptrWid:0] wr_ptr, rd_ptr;
  logic            infl, infl_last;
  logic [1:0]      cnt, occ;
  logic [width:0]  b0, b1;
  logic [width:0]  push_w;

  logic accept, wr_ok, beat, issue, done_d;

  assign st.s_ready = (state_q == LOAD);
  assign accept     = st.s_ready & st.s_valid;
  assign wr_ok      = (wr_ptr < DEPTH);

  assign st.m_valid = (cnt != 2'd0);
  assign st.m_data  = b0[width-1:0];
  assign st.m_last  = st.m_valid & b0[width];
  assign beat       = st.m_valid & st.m_ready;

  // A pop this cycle frees a slot, so a read may issue behind it.
  assign occ   = cnt + {1'b0, infl};
  assign issue = (state_q == READ) && (rd_ptr < ref_len)
              && ((occ < 2'd2) || beat);

  assign mem_wen  = accept & wr_ok;
  assign mem_din  = mem_wen ? st.s_data : '0;
  assign busy     = (state_q != IDLE);
  assign push_w   = {infl_last, mem_dout};

  always_comb begin
    mem_addr = '0;
    if (mem_wen)
      mem_addr = wr_ptr[ptrWid-1:0];
    else if (issue)
      mem_addr = rd_ptr[ptrWid-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ld_start)
          state_d = LOAD;
        else if (rd_start)
          state_d = READ;
      end
      LOAD: begin
        if (accept && st.s_last)
          state_d = IDLE;
      end
      READ: begin
        if (ref_len == '0)
          state_d = IDLE;
        else if (beat && st.m_last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      done      <= 1'b0;
      err_ovf   <= 1'b0;
      ref_len   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
      cnt       <= '0;
      b0        <= '0;
      b1        <= '0;
    end else begin
      state_q   <= state_d;
      done      <= done_d;
      infl      <= issue;
      infl_last <= issue && (rd_ptr + ONE == ref_len);

      if (state_q == IDLE) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        if (ld_start)
          err_ovf <= 1'b0;
      end

      if (mem_wen)
        wr_ptr <= wr_ptr + ONE;
      if (accept && !wr_ok)
        err_ovf <= 1'b1;
      if (accept && st.s_last)
        ref_len <= wr_ok ? wr_ptr + ONE : DEPTH;
      if (issue)
        rd_ptr <= rd_ptr + ONE;

      case ({infl, beat})
        2'b10: begin
          if (cnt == 2'd0)
            b0 <= push_w;
          else
            b1 <= push_w;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          b0  <= b1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            b0 <= push_w;
          end else begin
            b0 <= b1;
            b1 <= push_w;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_mem_ctrl.sv
// Directed bench for dtw_mem_ctrl with an 8-word BRAM model.
// Covers load, full-rate and stalled readback, overflow, empty read, abort.
module tb_dtw_mem_ctrl;

  localparam int W = 16;
  localparam int P = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ld_start = 1'b0;
  logic          rd_start = 1'b0;
  logic          busy, done, err_ovf;
  logic [P:0]    ref_len;
  logic          mem_wen;
  logic [P-1:0]  mem_addr;
  logic [W-1:0]  mem_din;
  logic [W-1:0]  mem_dout;
  logic [W-1:0]  bram [8];

  int tests = 0;
  int fails = 0;

  dtw_mem_ctrl_if #(.width(W)) st ();

  dtw_mem_ctrl #(.width(W), .ptrWid(P)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ld_start (ld_start),
    .rd_start (rd_start),
    .st       (st),
    .busy     (busy),
    .done     (done),
    .err_ovf  (err_ovf),
    .ref_len  (ref_len),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen)
      bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int n, input logic [15:0] base,
                         input bit both, input int prev_len);
    ld_start = 1'b1;
    rd_start = both;
    @(posedge clk); #1;
    ld_start = 1'b0;
    rd_start = 1'b0;
    chk("ld_busy", 32'(busy), 1);
    chk("ld_sready", 32'(st.s_ready), 1);
    chk("ld_ovf_clr", 32'(err_ovf), 0);
    if (both) begin
      rd_start = 1'b1;
      @(posedge clk); #1;
      rd_start = 1'b0;
      chk("both_load", 32'(st.s_ready), 1);
      chk("both_len", 32'(ref_len), 32'(prev_len));
    end
    for (int i = 0; i < n; i++) begin
      st.s_valid = 1'b1;
      st.s_data  = base + 16'(i);
      st.s_last  = (i == n - 1);
      #1;
      chk("ld_wen", 32'(mem_wen), 32'(i < 8));
      chk("ld_addr", 32'(mem_addr), (i < 8) ? 32'(i) : 0);
      if (i < 8)
        chk("ld_din", 32'(mem_din), 32'(base) + 32'(i));
      @(posedge clk); #1;
    end
    st.s_valid = 1'b0;
    st.s_last  = 1'b0;
    chk("ld_done", 32'(done), 1);
    chk("ld_idle", 32'(busy), 0);
    chk("ld_len", 32'(ref_len), (n < 8) ? 32'(n) : 8);
    chk("ld_ovf", 32'(err_ovf), 32'(n > 8));
    @(posedge clk); #1;
    chk("ld_done_pulse", 32'(done), 0);
  endtask

  task automatic do_read(input int n, input logic [15:0] base,
                         input int mode, input int abort_at);
    int   cyc;
    int   got;
    int   first;
    logic held;
    logic [15:0] hd;
    cyc = 0; got = 0; first = -1; held = 1'b0; hd = '0;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    chk("rd_busy", 32'(busy), 1);
    while (got < n && cyc < 200) begin
      if (abort_at > 0 && got == abort_at)
        break;
      st.m_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      #1;
      if (st.m_valid) begin
        if (first < 0)
          first = cyc;
        if (held)
          chk("rd_hold", 32'(st.m_data), 32'(hd));
        if (st.m_ready) begin
          chk("rd_data", 32'(st.m_data), 32'(base) + 32'(got));
          chk("rd_last", 32'(st.m_last), 32'(got == n - 1));
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = st.m_data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    st.m_ready = 1'b0;
    if (abort_at == 0) begin
      chk("rd_count", 32'(got), 32'(n));
      chk("rd_done", 32'(done), 1);
      chk("rd_idle", 32'(busy), 0);
      chk("rd_valid_off", 32'(st.m_valid), 0);
      if (mode == 0) begin
        chk("rd_first", 32'(first), 2);
        chk("rd_rate", 32'(cyc), 32'(n + 2));
      end
      @(posedge clk); #1;
      chk("rd_done_pulse", 32'(done), 0);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_sready"}, 32'(st.s_ready), 0);
    chk({tag, "_mvalid"}, 32'(st.m_valid), 0);
    chk({tag, "_mlast"}, 32'(st.m_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ovf"}, 32'(err_ovf), 0);
    chk({tag, "_len"}, 32'(ref_len), 0);
    chk({tag, "_wen"}, 32'(mem_wen), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
  endtask

  initial begin
    st.s_valid = 1'b0;
    st.s_data  = '0;
    st.s_last  = 1'b0;
    st.m_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rstn = 1'b1;
    @(posedge clk); #1;

    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    chk("empty_busy", 32'(busy), 1);
    chk("empty_valid", 32'(st.m_valid), 0);
    chk("empty_done0", 32'(done), 0);
    @(posedge clk); #1;
    chk("empty_idle", 32'(busy), 0);
    chk("empty_done", 32'(done), 1);
    chk("empty_valid2", 32'(st.m_valid), 0);
    @(posedge clk); #1;
    chk("empty_pulse", 32'(done), 0);

    do_load(5, 16'h0011, 1'b0, 0);
    do_read(5, 16'h0011, 0, 0);
    do_read(5, 16'h0011, 1, 0);

    do_load(10, 16'h0100, 1'b0, 5);
    do_read(8, 16'h0100, 0, 0);

    do_load(3, 16'h0200, 1'b1, 8);
    do_read(3, 16'h0200, 0, 0);

    do_load(5, 16'h0011, 1'b0, 3);
    do_read(5, 16'h0011, 0, 2);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("abort");
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("abort_nodone", 32'(done), 0);
    chk("abort_idle", 32'(busy), 0);
    do_load(3, 16'h0300, 1'b0, 0);
    do_read(3, 16'h0300, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
